div36: RTL and testbench

DIV36 -- requirements
Module: div36

---
 rtl/macc_pkg.sv | 28 ++
 rtl/div_step.sv | 24 ++
 rtl/div36.sv | 166 ++++++++++++++++
 tb/tb_div36.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/macc_pkg.sv
// Shared widths, FSM state encoding and quotient saturation bounds for the
// div36 signed divider.
package macc_pkg;

  localparam int DVD_W_DEF = 36;
  localparam int DVS_W_DEF = 18;
  localparam int CNT_W     = 6;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } state_e;

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  localparam longint SAT_MAX_DEF = sat_max(DVS_W_DEF);
  localparam longint SAT_MIN_DEF = sat_min(DVS_W_DEF);

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift in the next dividend bit,
// try subtracting the divisor, keep the difference if it did not go negative.
module div_step #(
  parameter int W = 18
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // rem_i < dvs_i always holds, so the difference fits a W+1-bit signed value.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, dvs_i};
    q_o     = ~diff[W];
    rem_o   = q_o ? diff[W-1:0] : shifted[W-1:0];
  end

endmodule

// File: rtl/div36.sv
// Multi-cycle signed restoring divider with saturating quotient, truncating
// remainder and valid/ready handshakes on both sides.
module div36
  import macc_pkg::*;
#(
  parameter int DVD_W = DVD_W_DEF,
  parameter int DVS_W = DVS_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DVS_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             ovf,
  output logic             div0
);

  localparam logic [DVS_W-1:0] Q_MAX   = DVS_W'(sat_max(DVS_W));
  localparam logic [DVS_W-1:0] Q_MIN   = DVS_W'(sat_min(DVS_W));
  localparam logic [DVD_W-1:0] NEG_LIM = DVD_W'(1) << (DVS_W - 1);
  localparam logic [DVD_W-1:0] POS_LIM = NEG_LIM - DVD_W'(1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(DVD_W - 1);

  state_e             state_q, state_d;
  logic [DVD_W-1:0]   dvd_q, dvd_d;
  logic [DVS_W-1:0]   dvs_q, dvs_d;
  logic [DVD_W-1:0]   qacc_q, qacc_d;
  logic [DVS_W-1:0]   rem_q, rem_d;
  logic [DVS_W-1:0]   dmag_q, dmag_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DVS_W-1:0]   quotient_q, quotient_d;
  logic [DVS_W-1:0]   remainder_q, remainder_d;
  logic               ovf_q, ovf_d;
  logic               div0_q, div0_d;

  logic [DVS_W-1:0]   step_rem;
  logic               step_bit;

  div_step #(.W(DVS_W)) u_step (
    .rem_i (rem_q),
    .bit_i (qacc_q[DVD_W-1]),
    .dvs_i (dmag_q),
    .rem_o (step_rem),
    .q_o   (step_bit)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign ovf       = ovf_q;
  assign div0      = div0_q;

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    qacc_d      = qacc_q;
    rem_d       = rem_q;
    dmag_d      = dmag_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ovf_d       = ovf_q;
    div0_d      = div0_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          state_d = PREP;
        end
      end
      PREP: begin
        if (dvs_q == '0) begin
          quotient_d  = dvd_q[DVD_W-1] ? Q_MIN : Q_MAX;
          remainder_d = '0;
          div0_d      = 1'b1;
          ovf_d       = 1'b0;
          state_d     = DONE;
        end else begin
          // Magnitude of the most negative dividend is representable unsigned.
          qacc_d  = dvd_q[DVD_W-1] ? -dvd_q : dvd_q;
          dmag_d  = dvs_q[DVS_W-1] ? -dvs_q : dvs_q;
          rem_d   = '0;
          cnt_d   = '0;
          neg_q_d = dvd_q[DVD_W-1] ^ dvs_q[DVS_W-1];
          neg_r_d = dvd_q[DVD_W-1];
          div0_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = ITER;
        end
      end
      ITER: begin
        qacc_d = {qacc_q[DVD_W-2:0], step_bit};
        rem_d  = step_rem;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        ovf_d = 1'b0;
        if (neg_q_q) begin
          if (qacc_q > NEG_LIM) begin
            quotient_d = Q_MIN;
            ovf_d      = 1'b1;
          end else begin
            quotient_d = -qacc_q[DVS_W-1:0];
          end
        end else if (qacc_q > POS_LIM) begin
          quotient_d = Q_MAX;
          ovf_d      = 1'b1;
        end else begin
          quotient_d = qacc_q[DVS_W-1:0];
        end
        remainder_d = neg_r_q ? -rem_q : rem_q;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      qacc_q      <= '0;
      rem_q       <= '0;
      dmag_q      <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ovf_q       <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      qacc_q      <= qacc_d;
      rem_q       <= rem_d;
      dmag_q      <= dmag_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ovf_q       <= ovf_d;
      div0_q      <= div0_d;
    end
  end

endmodule

// File: tb/tb_div36.sv
// Directed and randomized checks of div36 against an arithmetic reference
// model built on the language's own truncating signed division.
module tb_div36;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [35:0]        dividend;
  logic [17:0]        divisor;
  logic               out_valid;
  logic               out_ready;
  logic signed [17:0] quotient;
  logic signed [17:0] remainder;
  logic               ovf;
  logic               div0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div36 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .div0      (div0)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input longint a, input longint d,
                                output longint q, output longint r,
                                output longint ov, output longint dz);
    if (d == 0) begin
      dz = 1; ov = 0; r = 0;
      q  = (a >= 0) ? 131071 : -131072;
    end else begin
      dz = 0; ov = 0;
      q  = a / d;
      r  = a % d;
      if (q > 131071)  begin q = 131071;  ov = 1; end
      if (q < -131072) begin q = -131072; ov = 1; end
    end
  endfunction

  function automatic longint rnd_signed(input int w);
    longint t;
    t = {$urandom(), $urandom()};
    t = t <<< (64 - w);
    return t >>> (64 - w);
  endfunction

  task automatic run_op(input longint a, input longint d, input int hold);
    longint eq, er, eov, edz;
    int lat;
    model(a, d, eq, er, eov, edz);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    dividend = a[35:0];
    divisor  = d[17:0];
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      in_valid = 1'b0;
      dividend = 36'($urandom());
      divisor  = 18'($urandom());
    end while (!out_valid && lat < 60);
    chk("out_valid", out_valid, 1);
    chk("latency", lat, (edz != 0) ? 2 : 39);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("ovf", ovf, eov);
    chk("div0", div0, edz);
    chk("in_ready_busy", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_quotient", quotient, eq);
      chk("hold_remainder", remainder, er);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after", in_ready, 1);
    chk("out_valid_after", out_valid, 0);
    $display("op %0d / %0d -> q=%0d r=%0d ovf=%0b div0=%0b lat=%0d",
             a, d, quotient, remainder, ovf, div0, lat);
  endtask

  initial begin
    int seen;
    longint a, d;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_div0", div0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(1000, 7, 10);
    run_op(-1000, 7, 0);
    run_op(1000, -7, 0);
    run_op(1000, 0, 0);
    run_op(-5, 0, 0);
    run_op(longint'(1) <<< 20, 1, 0);
    run_op(-(longint'(1) <<< 35), -1, 0);
    run_op(-131072, 1, 0);
    run_op(131072, -1, 0);
    run_op(0, -3, 2);

    // Abort an operation part-way through its iterations.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 36'd12345;
    divisor  = 18'd67;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);
    $display("op reset-abort 12345 / 67 -> stray results=%0d", seen);
    run_op(77, -3, 0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       begin a = rnd_signed(36); d = rnd_signed(18); end
        1:       begin a = rnd_signed(21); d = rnd_signed(8);  end
        2:       begin a = rnd_signed(30); d = rnd_signed(18); end
        default: begin a = rnd_signed(36); d = rnd_signed(2);  end
      endcase
      run_op(a, d, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
